// File: rtl/simmem_write_requester.sv
// Write-side traffic generator for the simulated memory controller: queues burst commands and
// drives AW and W independently, letting W lead AW by at most MaxDataLead beats.

package simmem_pkg;
  localparam int unsigned IdWidth          = 4;
  localparam int unsigned AddrWidth        = 32;
  localparam int unsigned MaxBurstLenField = 4;
  localparam int unsigned MaxBurstEffLen   = 1 << MaxBurstLenField;
  localparam int unsigned EffLenW          = MaxBurstLenField + 1;

  typedef struct packed {
    logic [IdWidth-1:0]          id;
    logic [AddrWidth-1:0]        addr;
    logic [MaxBurstLenField-1:0] burst_len;
  } waddr_t;

  // AXI-style encoding: a burst_len field of N means N+1 beats.
  function automatic logic [EffLenW-1:0] get_effective_burst_len(
      input logic [MaxBurstLenField-1:0] burst_len);
    return {1'b0, burst_len} + EffLenW'(1);
  endfunction
endpackage

module simmem_write_requester
  import simmem_pkg::*;
#(
  parameter int unsigned CmdDepth    = 4,
  parameter int unsigned MaxDataLead = 8
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  waddr_t cmd_waddr_i,
  input  logic   cmd_valid_i,
  output logic   cmd_ready_o,
  input  logic   aw_en_i,
  input  logic   w_en_i,
  output waddr_t waddr_o,
  output logic   waddr_valid_o,
  input  logic   waddr_ready_i,
  output logic   wdata_valid_o,
  output logic   wdata_last_o,
  input  logic   wdata_ready_i,
  output logic signed [$clog2(MaxBurstEffLen*CmdDepth)+1:0] lead_cnt_o
);

  localparam int unsigned IdxW  = $clog2(CmdDepth);
  localparam int unsigned PtrW  = IdxW + 1;
  localparam int unsigned LeadW = $clog2(MaxBurstEffLen * CmdDepth) + 2;

  waddr_t                      mem_q [CmdDepth];
  logic   [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic   [PtrW-1:0]           aw_ptr_q, aw_ptr_d;
  logic   [PtrW-1:0]           w_ptr_q, w_ptr_d;
  logic   [PtrW-1:0]           occ_q, occ_d;
  logic   [PtrW-1:0]           aw_occ, w_occ;
  logic   [MaxBurstLenField-1:0] beat_cnt_q, beat_cnt_d;
  logic signed [LeadW-1:0]     lead_cnt_q, lead_cnt_d;
  logic signed [LeadW-1:0]     aw_len;
  logic                        lead_ok;
  logic                        enq, aw_hs, w_hs;

  // Output/valid logic depends only on registered state and the enables, never on readies.
  always_comb begin
    lead_ok       = lead_cnt_q < $signed(LeadW'(MaxDataLead));
    cmd_ready_o   = occ_q < PtrW'(CmdDepth);
    waddr_o       = mem_q[aw_ptr_q[IdxW-1:0]];
    waddr_valid_o = aw_en_i && (aw_ptr_q != wr_ptr_q);
    wdata_valid_o = w_en_i && (w_ptr_q != wr_ptr_q) && lead_ok;
    wdata_last_o  = wdata_valid_o && (beat_cnt_q == mem_q[w_ptr_q[IdxW-1:0]].burst_len);
    lead_cnt_o    = lead_cnt_q;
    aw_len        = LeadW'(get_effective_burst_len(waddr_o.burst_len));
  end

  assign enq   = cmd_valid_i && cmd_ready_o;
  assign aw_hs = waddr_valid_o && waddr_ready_i;
  assign w_hs  = wdata_valid_o && wdata_ready_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    aw_ptr_d   = aw_ptr_q;
    w_ptr_d    = w_ptr_q;
    beat_cnt_d = beat_cnt_q;
    lead_cnt_d = lead_cnt_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (aw_hs) begin
      aw_ptr_d   = aw_ptr_q + PtrW'(1);
      lead_cnt_d = lead_cnt_d - aw_len;
    end
    if (w_hs) begin
      lead_cnt_d = lead_cnt_d + LeadW'(1);
      if (wdata_last_o) begin
        beat_cnt_d = '0;
        w_ptr_d    = w_ptr_q + PtrW'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + MaxBurstLenField'(1);
      end
    end
    // An entry stays occupied until the slower of the AW and W paths has passed it.
    aw_occ = wr_ptr_d - aw_ptr_d;
    w_occ  = wr_ptr_d - w_ptr_d;
    occ_d  = (aw_occ > w_occ) ? aw_occ : w_occ;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      aw_ptr_q   <= '0;
      w_ptr_q    <= '0;
      occ_q      <= '0;
      beat_cnt_q <= '0;
      lead_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      aw_ptr_q   <= aw_ptr_d;
      w_ptr_q    <= w_ptr_d;
      occ_q      <= occ_d;
      beat_cnt_q <= beat_cnt_d;
      lead_cnt_q <= lead_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q[IdxW-1:0]] <= cmd_waddr_i;
    end
  end

endmodule

// File: tb/tb_simmem_write_requester.sv
// Directed bench for simmem_write_requester: three instances (MaxDataLead 0, 8, 2) share stimulus;
// each step checks the instance whose lead limit the step targets.

module tb_simmem_write_requester;
  import simmem_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned LeadW = $clog2(MaxBurstEffLen * Depth) + 2;
  localparam int L0 = 0;
  localparam int L8 = 1;
  localparam int L2 = 2;

  logic   clk_i = 1'b0;
  logic   rst_i;
  waddr_t cmd_waddr;
  logic   cmd_valid, aw_en, w_en, waddr_ready, wdata_ready;

  logic             cmd_ready   [3];
  waddr_t           waddr       [3];
  logic             waddr_valid [3];
  logic             wdata_valid [3];
  logic             wdata_last  [3];
  logic [LeadW-1:0] lead        [3];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  simmem_write_requester #(.CmdDepth(Depth), .MaxDataLead(0)) u_l0 (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_waddr_i(cmd_waddr), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready[L0]), .aw_en_i(aw_en), .w_en_i(w_en), .waddr_o(waddr[L0]),
    .waddr_valid_o(waddr_valid[L0]), .waddr_ready_i(waddr_ready),
    .wdata_valid_o(wdata_valid[L0]), .wdata_last_o(wdata_last[L0]),
    .wdata_ready_i(wdata_ready), .lead_cnt_o(lead[L0])
  );

  simmem_write_requester #(.CmdDepth(Depth), .MaxDataLead(8)) u_l8 (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_waddr_i(cmd_waddr), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready[L8]), .aw_en_i(aw_en), .w_en_i(w_en), .waddr_o(waddr[L8]),
    .waddr_valid_o(waddr_valid[L8]), .waddr_ready_i(waddr_ready),
    .wdata_valid_o(wdata_valid[L8]), .wdata_last_o(wdata_last[L8]),
    .wdata_ready_i(wdata_ready), .lead_cnt_o(lead[L8])
  );

  simmem_write_requester #(.CmdDepth(Depth), .MaxDataLead(2)) u_l2 (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_waddr_i(cmd_waddr), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready[L2]), .aw_en_i(aw_en), .w_en_i(w_en), .waddr_o(waddr[L2]),
    .waddr_valid_o(waddr_valid[L2]), .waddr_ready_i(waddr_ready),
    .wdata_valid_o(wdata_valid[L2]), .wdata_last_o(wdata_last[L2]),
    .wdata_ready_i(wdata_ready), .lead_cnt_o(lead[L2])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lead(input string tag, input logic [LeadW-1:0] obs, input int exp);
    logic [LeadW-1:0] e;
    e = LeadW'(exp);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), exp);
    end
  endtask

  function automatic waddr_t mk_cmd(input logic [31:0] a, input logic [3:0] len);
    waddr_t c;
    c.id        = a[3:0];
    c.addr      = a;
    c.burst_len = len;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    cmd_valid   = 1'b0;
    aw_en       = 1'b1;
    w_en        = 1'b1;
    waddr_ready = 1'b1;
    wdata_ready = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
  endtask

  // One 4-beat burst on the MaxDataLead=0 instance: AW first, then W beats at t+2..t+5.
  task automatic run_basic(input string tag);
    cmd_waddr = mk_cmd(32'h0000_1000, 4'd3);
    cmd_valid = 1'b1;
    settle();
    chk({tag, "_cmd_ready"}, cmd_ready[L0], 1'b1);
    tick();
    cmd_valid = 1'b0;
    settle();
    chk({tag, "_aw_valid"}, waddr_valid[L0], 1'b1);
    chk({tag, "_aw_addr"}, waddr[L0].addr, 32'h0000_1000);
    chk({tag, "_w_held"}, wdata_valid[L0], 1'b0);
    tick();
    settle();
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_w_valid"}, wdata_valid[L0], 1'b1);
      chk({tag, "_w_last"}, wdata_last[L0], (i == 3));
      chk_lead({tag, "_lead"}, lead[L0], -4 + i);
      chk({tag, "_aw_done"}, waddr_valid[L0], 1'b0);
      tick();
      settle();
    end
    chk({tag, "_w_idle"}, wdata_valid[L0], 1'b0);
    chk_lead({tag, "_lead_end"}, lead[L0], 0);
  endtask

  initial begin
    cmd_waddr = '0;
    do_reset();
    tick();
    settle();
    chk("rst_cmd_ready", cmd_ready[L0], 1'b1);
    chk("rst_aw_valid", waddr_valid[L0], 1'b0);
    chk("rst_w_valid", wdata_valid[L0], 1'b0);
    chk("rst_w_last", wdata_last[L0], 1'b0);
    chk_lead("rst_lead", lead[L0], 0);

    // MaxDataLead=0: no data before address.
    do_reset();
    run_basic("basic");

    // MaxDataLead=8 with AW held off: W drains both bursts ahead of their addresses.
    do_reset();
    aw_en     = 1'b0;
    cmd_waddr = mk_cmd(32'h0000_2000, 4'd3);
    cmd_valid = 1'b1;
    settle();
    chk("lead8_w_empty", wdata_valid[L8], 1'b0);
    tick();
    cmd_waddr = mk_cmd(32'h0000_3000, 4'd3);
    settle();
    for (int i = 0; i < 8; i++) begin
      chk("lead8_w_valid", wdata_valid[L8], 1'b1);
      chk("lead8_w_last", wdata_last[L8], (i == 3) || (i == 7));
      chk_lead("lead8_lead", lead[L8], i);
      tick();
      cmd_valid = 1'b0;
      settle();
    end
    chk("lead8_w_stop", wdata_valid[L8], 1'b0);
    chk_lead("lead8_lead_max", lead[L8], 8);
    chk("lead8_aw_gated", waddr_valid[L8], 1'b0);
    chk("lead8_cmd_ready", cmd_ready[L8], 1'b1);
    aw_en = 1'b1;
    settle();
    chk("lead8_aw0_valid", waddr_valid[L8], 1'b1);
    chk("lead8_aw0_addr", waddr[L8].addr, 32'h0000_2000);
    tick();
    settle();
    chk_lead("lead8_lead_4", lead[L8], 4);
    chk("lead8_aw1_addr", waddr[L8].addr, 32'h0000_3000);
    tick();
    settle();
    chk_lead("lead8_lead_0", lead[L8], 0);
    chk("lead8_aw_idle", waddr_valid[L8], 1'b0);
    chk("lead8_ready_end", cmd_ready[L8], 1'b1);

    // MaxDataLead=2: two beats, then blocked until the cycle after the AW handshake.
    do_reset();
    aw_en     = 1'b0;
    cmd_waddr = mk_cmd(32'h0000_4000, 4'd3);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    settle();
    chk("lead2_b0_valid", wdata_valid[L2], 1'b1);
    chk_lead("lead2_b0_lead", lead[L2], 0);
    tick();
    settle();
    chk("lead2_b1_valid", wdata_valid[L2], 1'b1);
    chk("lead2_b1_last", wdata_last[L2], 1'b0);
    tick();
    settle();
    chk("lead2_block", wdata_valid[L2], 1'b0);
    chk_lead("lead2_lead_2", lead[L2], 2);
    tick();
    settle();
    chk("lead2_block2", wdata_valid[L2], 1'b0);
    aw_en = 1'b1;
    settle();
    chk("lead2_aw_valid", waddr_valid[L2], 1'b1);
    chk("lead2_block_aw", wdata_valid[L2], 1'b0);
    tick();
    settle();
    chk("lead2_b2_valid", wdata_valid[L2], 1'b1);
    chk("lead2_b2_last", wdata_last[L2], 1'b0);
    chk_lead("lead2_lead_m2", lead[L2], -2);
    tick();
    settle();
    chk("lead2_b3_last", wdata_last[L2], 1'b1);
    tick();
    settle();
    chk("lead2_idle", wdata_valid[L2], 1'b0);
    chk_lead("lead2_lead_0", lead[L2], 0);

    // Full queue: four accepted, fifth refused until the head entry fully retires.
    do_reset();
    aw_en     = 1'b0;
    w_en      = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_waddr = mk_cmd(32'h100 + 32'(i), 4'd1);
      settle();
      chk("full_accept", cmd_ready[L8], 1'b1);
      tick();
    end
    cmd_waddr = mk_cmd(32'h104, 4'd1);
    settle();
    chk("full_refuse", cmd_ready[L8], 1'b0);
    tick();
    aw_en = 1'b1;
    w_en  = 1'b1;
    settle();
    chk("full_e0_ready", cmd_ready[L8], 1'b0);
    chk("full_e0_addr", waddr[L8].addr, 32'h100);
    chk("full_e0_w", wdata_valid[L8], 1'b1);
    chk("full_e0_last", wdata_last[L8], 1'b0);
    tick();
    settle();
    chk("full_e1_ready", cmd_ready[L8], 1'b0);
    chk("full_e1_last", wdata_last[L8], 1'b1);
    chk("full_e1_addr", waddr[L8].addr, 32'h101);
    chk_lead("full_e1_lead", lead[L8], -1);
    tick();
    settle();
    chk("full_e2_ready", cmd_ready[L8], 1'b1);
    chk_lead("full_e2_lead", lead[L8], -2);
    tick();
    cmd_valid = 1'b0;

    // W back-pressure on the last beat: valid, last and lead hold.
    do_reset();
    cmd_waddr = mk_cmd(32'h0000_5000, 4'd3);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    wdata_ready = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", wdata_valid[L0], 1'b1);
      chk("stall_last", wdata_last[L0], 1'b1);
      chk_lead("stall_lead", lead[L0], -1);
      tick();
      settle();
    end
    wdata_ready = 1'b1;
    settle();
    chk("stall_release", wdata_valid[L0], 1'b1);
    tick();
    settle();
    chk("stall_done", wdata_valid[L0], 1'b0);
    chk_lead("stall_lead_end", lead[L0], 0);

    // Reset after two of four beats discards everything.
    do_reset();
    cmd_waddr = mk_cmd(32'h0000_6000, 4'd3);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    chk("mid_rst_aw", waddr_valid[L0], 1'b0);
    chk("mid_rst_w", wdata_valid[L0], 1'b0);
    chk("mid_rst_last", wdata_last[L0], 1'b0);
    chk("mid_rst_ready", cmd_ready[L0], 1'b1);
    chk_lead("mid_rst_lead", lead[L0], 0);
    run_basic("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
